// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// A valid/ready load fills a one-entry pending buffer; the pending value is copied to the
// displayed shadow only at a frame boundary, so one scan never mixes old and new digits.
// Each digit slot opens with GUARD blanked cycles to suppress ghosting between digits.
// Optional feature: define SEVSEG_LZB_EN to blank leading zeros on digits 3..1.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned GUARD       = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_in,
  output logic [7:0]  seven_seg,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);

  // Segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // State
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          full_q, full_d;
  logic [15:0]   shadow_data_q, shadow_data_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [7:0]    seven_seg_q, seven_seg_d;
  logic [3:0]    digit_en_q, digit_en_d;
  logic          frame_done_q, frame_done_d;

  // Decode-side signals
  logic          presc_wrap;
  logic          boundary;
  logic          accept;
  logic          in_guard;
  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic [3:0]    lz_mask;

  assign presc_wrap = (presc_q == PrescLast);
  assign boundary   = presc_wrap && (idx_q == 2'd3);
  assign load_ready = !full_q;
  assign accept     = load_valid && !full_q;
  assign in_guard   = (32'(presc_q) < GUARD);

  // Prescaler and digit index advance.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_wrap) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Pending buffer and shadow transfer. Transfer only uses the full flag as it stood
  // before the boundary cycle, so an accept in that same cycle waits a whole frame.
  // Accept and transfer can never coincide: accept needs full clear, transfer needs it set.
  always_comb begin
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    full_d        = full_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (boundary && full_q) begin
      shadow_data_d = pend_data_q;
      shadow_dp_d   = pend_dp_q;
      full_d        = 1'b0;
    end
    if (accept) begin
      pend_data_d = bcd_in;
      pend_dp_d   = dp_in;
      full_d      = 1'b1;
    end
  end

  // Select the nibble and decimal point of the digit currently being scanned.
  always_comb begin
    cur_nib = shadow_data_q[3:0];
    cur_dp  = shadow_dp_q[0];
    unique case (idx_q)
      2'd0: begin cur_nib = shadow_data_q[3:0];   cur_dp = shadow_dp_q[0]; end
      2'd1: begin cur_nib = shadow_data_q[7:4];   cur_dp = shadow_dp_q[1]; end
      2'd2: begin cur_nib = shadow_data_q[11:8];  cur_dp = shadow_dp_q[2]; end
      2'd3: begin cur_nib = shadow_data_q[15:12]; cur_dp = shadow_dp_q[3]; end
      default: begin cur_nib = 4'h0; cur_dp = 1'b0; end
    endcase
  end

`ifdef SEVSEG_LZB_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 always shows, so a zero value still reads "0".
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (shadow_data_q[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (shadow_data_q[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (shadow_data_q[7:4] == 4'h0);
    lz_mask[0] = 1'b0;
  end
`else
  assign lz_mask = 4'b0000;
`endif

  // Next registered display value; blank_in and the guard window only gate outputs.
  always_comb begin
    seven_seg_d  = 8'h00;
    digit_en_d   = 4'b0000;
    frame_done_d = boundary;
    if (!blank_in && !in_guard) begin
      digit_en_d  = 4'b0001 << idx_q;
      seven_seg_d = {cur_dp, (lz_mask[idx_q] ? 7'h00 : seg_decode(cur_nib))};
    end
  end

  // All state, synchronous active-high reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      presc_q       <= '0;
      idx_q         <= 2'd0;
      pend_data_q   <= 16'h0000;
      pend_dp_q     <= 4'b0000;
      full_q        <= 1'b0;
      shadow_data_q <= 16'h0000;
      shadow_dp_q   <= 4'b0000;
      seven_seg_q   <= 8'h00;
      digit_en_q    <= 4'b0000;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      full_q        <= full_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      seven_seg_q   <= seven_seg_d;
      digit_en_q    <= digit_en_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seven_seg  = seven_seg_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

  // Digit select is never more than one-hot.
  a_digit_onehot: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    $onehot0(digit_en));

  // No segment lights without a selected digit.
  a_seg_needs_digit: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    (digit_en == 4'b0000) |-> (seven_seg == 8'h00));

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with REFRESH_DIV=8, GUARD=2 (32-cycle frames).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        blank_in = 1'b0;
  logic [7:0]  seven_seg;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  sevenseg_scan_driver #(
    .REFRESH_DIV(8),
    .GUARD      (2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .blank_in  (blank_in),
    .seven_seg (seven_seg),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected patterns for the all-zero and 0x0007 displays.
`ifdef SEVSEG_LZB_EN
  localparam logic [7:0] Z3 = 8'h00, Z2 = 8'h00, Z1 = 8'h00;
`else
  localparam logic [7:0] Z3 = 8'h3F, Z2 = 8'h3F, Z1 = 8'h3F;
`endif

  task automatic step();
    @(negedge clk);
  endtask

  // Walk one frame whose first state cycle is the current one; one check per digit slot.
  task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_seg [4];
    logic [7:0] want_seg, bad_wseg, bad_gseg;
    logic [3:0] want_den, bad_wden, bad_gden;
    logic       want_fd, bad_wfd, bad_gfd;
    int         bad_p;
    bit         bad;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    for (int k = 0; k < 4; k++) begin
      bad = 1'b0;
      bad_p = 0;
      bad_wseg = 8'h00; bad_gseg = 8'h00;
      bad_wden = 4'h0;  bad_gden = 4'h0;
      bad_wfd = 1'b0;   bad_gfd = 1'b0;
      for (int p = 0; p < 8; p++) begin
        step();
        load_valid = 1'b0;
        want_fd = (k == 3 && p == 7);
        if (p < 2) begin
          want_seg = 8'h00;
          want_den = 4'b0000;
        end else begin
          want_seg = exp_seg[k];
          want_den = 4'b0001 << k;
        end
        if (!bad && (seven_seg !== want_seg || digit_en !== want_den ||
                     frame_done !== want_fd)) begin
          bad = 1'b1;
          bad_p = p;
          bad_wseg = want_seg; bad_gseg = seven_seg;
          bad_wden = want_den; bad_gden = digit_en;
          bad_wfd = want_fd;   bad_gfd = frame_done;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s digit%0d slot cycle %0d: got en=%b seg=%h fd=%b, want en=%b seg=%h fd=%b",
                 name, k, bad_p, bad_gden, bad_gseg, bad_gfd, bad_wden, bad_wseg, bad_wfd);
      end
    end
  endtask

  // Advance until frame_done is seen, bounded.
  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_frame: got no frame_done, want one within 40 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad_i;
    do_reset();
    checks++;
    if (seven_seg !== 8'h00 || digit_en !== 4'b0000 || load_ready !== 1'b1 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got seg=%h en=%b rdy=%b fd=%b, want 00 0000 1 0",
               seven_seg, digit_en, load_ready, frame_done);
    end
    bad_i = -1;
    for (int i = 1; i <= 33; i++) begin
      step();
      if (bad_i < 0 && frame_done !== (i == 32)) bad_i = i;
    end
    checks++;
    if (bad_i >= 0) begin
      errors++;
      $display("FAIL first_frame_done: got wrong frame_done at cycle %0d, want pulse only at 32",
               bad_i);
    end
  endtask

  // Starts on a frame_done cycle; ends on the frame_done after the displayed frame.
  task automatic test_load(input string name, input logic [15:0] data, input logic [3:0] dp,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
    bcd_in = data;
    dp_in = dp;
    load_valid = 1'b1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b, want 1", name, load_ready);
    end
    step();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_accept: got %b, want 0", name, load_ready);
    end
    wait_frame(name);
    check_frame(name, e0, e1, e2, e3);
  endtask

  task automatic test_back_to_back();
    int n;
    bcd_in = 16'h1111;
    dp_in = 4'b0000;
    load_valid = 1'b1;
    step();
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b ready_after_first: got %b, want 0", load_ready);
    end
    bcd_in = 16'h2222;
    n = 0;
    do begin
      step();
      n++;
    end while (load_ready !== 1'b1 && n < 40);
    checks++;
    if (load_ready !== 1'b1 || frame_done !== 1'b1 || n != 31) begin
      errors++;
      $display("FAIL b2b stall: got rdy=%b fd=%b after %0d cycles, want rdy=1 fd=1 after 31",
               load_ready, frame_done, n);
    end
    // The second request is accepted on the first step of this frame.
    check_frame("b2b_first", 8'h06, 8'h06, 8'h06, 8'h06);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b ready_after_second_transfer: got %b, want 1", load_ready);
    end
    check_frame("b2b_second", 8'h5B, 8'h5B, 8'h5B, 8'h5B);
  endtask

  // Shadow holds 0xABCD, dp=0100.
  task automatic test_blank();
    bit bad;
    repeat (12) step();
    checks++;
    if (digit_en !== 4'b0010 || seven_seg !== 8'h39) begin
      errors++;
      $display("FAIL blank pre: got en=%b seg=%h, want 0010 39", digit_en, seven_seg);
    end
    blank_in = 1'b1;
    step();
    checks++;
    if (digit_en !== 4'b0000 || seven_seg !== 8'h00) begin
      errors++;
      $display("FAIL blank next_cycle: got en=%b seg=%h, want 0000 00", digit_en, seven_seg);
    end
    bad = 1'b0;
    repeat (7) begin
      step();
      if (digit_en !== 4'b0000 || seven_seg !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL blank hold: got nonzero output, want en=0000 seg=00");
    end
    blank_in = 1'b0;
    step();
    checks++;
    if (digit_en !== 4'b0100 || seven_seg !== 8'hFC) begin
      errors++;
      $display("FAIL blank resume: got en=%b seg=%h, want 0100 FC", digit_en, seven_seg);
    end
    repeat (11) step();
    checks++;
    if (frame_done !== 1'b1 || digit_en !== 4'b1000 || seven_seg !== 8'h77) begin
      errors++;
      $display("FAIL blank frame_timing: got fd=%b en=%b seg=%h, want 1 1000 77",
               frame_done, digit_en, seven_seg);
    end
  endtask

  task automatic test_reset_mid_frame();
    repeat (5) step();
    bcd_in = 16'h5555;
    dp_in = 4'b1111;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid pending: got ready=%b, want 0", load_ready);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if (seven_seg !== 8'h00 || digit_en !== 4'b0000 || load_ready !== 1'b1 ||
        frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid state: got seg=%h en=%b rdy=%b fd=%b, want 00 0000 1 0",
               seven_seg, digit_en, load_ready, frame_done);
    end
    rst = 1'b0;
    check_frame("rstmid_first", 8'h3F, Z1, Z2, Z3);
    check_frame("rstmid_second", 8'h3F, Z1, Z2, Z3);
  endtask

  initial begin
    test_reset();
    wait_frame("sync");
    test_load("load_1234", 16'h1234, 4'b0000, 8'h66, 8'h4F, 8'h5B, 8'h06);
    test_back_to_back();
    test_load("load_abcd", 16'hABCD, 4'b0100, 8'h5E, 8'h39, 8'hFC, 8'h77);
    test_blank();
    test_load("load_0007", 16'h0007, 4'b0000, 8'h07, Z1, Z2, Z3);
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Four-digit multiplexed seven-segment display driver for the user timer project. Accepts a 16-bit BCD/hex value plus per-digit decimal points over a valid/ready load interface, buffers it, and scans the digits onto `seven_seg` / `digit_en`, which map directly onto `io_out[11:0]`. Display updates are applied only at frame boundaries, so a digit never shows a mix of old and new data within one scan.

## Interface
Parameters:
- `REFRESH_DIV`, default 1000: clock cycles per digit slot; must be ≥ `GUARD`+2.
- `GUARD`, default 2: blanking cycles at the start of each slot (anti-ghosting); 0 is legal.

Ports:
- `wb_clk_i`  in  1  system clock; all logic on rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `bcd_in`  in  16  four nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `dp_in`  in  4  decimal point per digit; bit k belongs to digit k.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  pending buffer empty; load accepted on `load_valid & load_ready`.
- `blank_in`  in  1  forces `seven_seg` = 0 and `digit_en` = 0 while high.
- `seven_seg`  out  8  `{dp,g,f,e,d,c,b,a}`, active-high.
- `digit_en`  out  4  one-hot digit select, active-high.
- `frame_done`  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- Storage: a pending register (data, dp, full flag) and a shadow register (displayed data).
- Load: an accept writes the pending register and sets full; `load_ready` = !full, so it drops the cycle after an accept.
- Frame boundary: the cycle where scan index = 3 and prescaler = `REFRESH_DIV`-1. If full was set before this cycle, shadow ← pending and full clears. An accept in the boundary cycle itself is transferred at the next boundary.
- Scan: the prescaler counts 0..`REFRESH_DIV`-1 and wraps. On wrap, the scan index increments 0→1→2→3→0.
- Decode: each nibble maps to segments as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Bit 7 carries dp.
- Guard: while prescaler < `GUARD`, `seven_seg` = 0 and `digit_en` = 0. Otherwise `digit_en` = 1 << index and `seven_seg` = decode(shadow[index]).
- `blank_in` overrides the output values only; scan, prescaler and load operation continue.

## Timing
- Reset values: `seven_seg` = 0, `digit_en` = 0, `frame_done` = 0, `load_ready` = 1. Shadow = 0, pending empty, index = 0, prescaler = 0.
- Cycle n is counted from the first cycle with reset low. Prescaler = n mod `REFRESH_DIV`; index = (n / `REFRESH_DIV`) mod 4.
- Outputs are registered. Values at cycle n+1 reflect the index, prescaler and shadow state of cycle n.
- `frame_done` is high for exactly one cycle, at cycle n+1 where n is a boundary cycle.
- Load-to-display latency: from the accept to the first `frame_done`, plus up to one frame. The new value first appears in the digit-0 slot that follows that `frame_done`.
- Reset mid-frame: the next cycle equals the reset state. A pending load is discarded and the shadow is cleared.

## Configuration
- `SEVSEG_LZB_EN` defined: leading-zero blanking. Digit k (k = 3..1) has its segments a–g forced to 0 when its nibble and all higher nibbles are 0. dp is still driven from `dp_in` and `digit_en` still scans. Digit 0 is never blanked.
- `SEVSEG_LZB_EN` undefined: all digits are decoded; a zero shows 3F.

## Test plan
(`REFRESH_DIV` = 8, `GUARD` = 2)
- Reset: hold `wb_rst_i` 3 cycles → `seven_seg` = 00, `digit_en` = 0, `load_ready` = 1, `frame_done` = 0. First `frame_done` pulse occurs at cycle 32 after release.
- Load 0x1234, dp = 0 → after the next `frame_done`, the digit-0 slot shows `digit_en` = 0001 / `seven_seg` = 66 from slot cycle 2 to slot cycle 7 (00/0 in cycles 0–1). Digits 1–3 then show 4F, 5B, 06.
- Back-to-back loads 0x1111 then 0x2222 → `load_ready` low after the first accept. The second load stalls until the cycle after `frame_done`, is accepted, and is displayed one frame later.
- Load 0xABCD, dp = 0100 → the frame shows digit 0 = 5E, digit 1 = 39, digit 2 = FC, digit 3 = 77.
- Load 0x0007 → with `SEVSEG_LZB_EN`, digits 3..1 show 00 with `digit_en` still one-hot and digit 0 shows 07. Without it, digits 3..1 show 3F.
- Assert `blank_in` mid-slot → outputs are 0 from the next cycle; deassert → scan resumes with prescaler/index unaffected. Reset asserted mid-frame with a pending load → after release the display shows 3F (or blanked per LZB) and `load_ready` = 1.
